// File: rtl/pbch_pkg.sv
// pbch_pkg: constants, FSM state type and the c_init helper shared by the
// PBCH DMRS transmit generator and the receive-side correlator.
// No ports; import with pbch_pkg::*.
package pbch_pkg;

  localparam int PBCH_DMRS_LEN = 144;   // QPSK symbols per SSB
  localparam int GOLD_NC       = 1600;  // Gold sequence offset Nc
  localparam int MAX_CELL_ID   = 1007;  // highest valid N_id
  localparam int LFSR_N        = 31;    // x1/x2 register length

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WARMUP,
    OUTPUT
  } pbch_state_e;

  // c_init = ((ibar+1)*((N_id>>2)+1) << 11) + ((ibar+1) << 6) + N_id[1:0].
  // The product is at most 8*256, so 13 bits plus the 11-bit shift stays
  // well inside 31 bits; the result is zero-extended.
  function automatic logic [LFSR_N-1:0] calc_c_init(input logic [9:0] n_id,
                                                    input logic [2:0] ibar);
    logic [3:0]  ib1;
    logic [8:0]  q;
    logic [12:0] prod;
    ib1  = {1'b0, ibar} + 4'd1;
    q    = {1'b0, n_id[9:2]} + 9'd1;
    prod = 13'(ib1) * 13'(q);
    return (31'(prod) << 11) + (31'(ib1) << 6) + 31'(n_id[1:0]);
  endfunction

endpackage

// File: rtl/gold_seq2.sv
// gold_seq2: 38.211 length-31 Gold sequence generator, two steps per enable.
// Ports: clk_i, reset_ni (async low), load_i (x1<=1, x2<=c_init_i),
//        en_i (advance 2 steps), c_o = {c(n+1), c(n)} for the current state.
module gold_seq2
  import pbch_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              load_i,
  input  logic [LFSR_N-1:0] c_init_i,
  input  logic              en_i,
  output logic [1:0]        c_o
);

  // Bit k of each register holds x(n+k), so bit 0 is the oldest element.
  logic [LFSR_N-1:0] x1_q, x1_d;
  logic [LFSR_N-1:0] x2_q, x2_d;

  always_comb begin
    // x1(n+31) = x1(n+3)^x1(n); the second feedback is the same tap set
    // shifted by one, which stays within the current register contents.
    x1_d = {x1_q[4] ^ x1_q[1],
            x1_q[3] ^ x1_q[0],
            x1_q[LFSR_N-1:2]};
    x2_d = {x2_q[4] ^ x2_q[3] ^ x2_q[2] ^ x2_q[1],
            x2_q[3] ^ x2_q[2] ^ x2_q[1] ^ x2_q[0],
            x2_q[LFSR_N-1:2]};
    c_o  = {x1_q[1] ^ x2_q[1], x1_q[0] ^ x2_q[0]};
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      x1_q <= '0;
      x2_q <= '0;
    end else if (load_i) begin
      x1_q <= LFSR_N'(1);
      x2_q <= c_init_i;
    end else if (en_i) begin
      x1_q <= x1_d;
      x2_q <= x2_d;
    end
  end

endmodule

// File: rtl/pbch_dmrs_gen.sv
// pbch_dmrs_gen: PBCH DMRS QPSK generator streaming 144 symbols over AXI-S.
// Ports: clk_i, reset_ni, N_id_i/ibar_SSB_i/start_i request, m_axis_out_*
//        (tdata = {imag, real}), busy_o, debug_c_init_o (c_init of last LOAD).
module pbch_dmrs_gen #(
  parameter int OUT_DW = 32,
  parameter int AMP    = 23170
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [9:0]        N_id_i,
  input  logic [2:0]        ibar_SSB_i,
  input  logic              start_i,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast,
  output logic              busy_o,
  output logic [30:0]       debug_c_init_o
);
  import pbch_pkg::*;

  localparam int HW = OUT_DW / 2;
  localparam logic signed [HW-1:0] POS = HW'(AMP);
  localparam logic signed [HW-1:0] NEG = -POS;

  pbch_state_e state_q, state_d;

  logic [10:0]       cnt_q, cnt_d;
  logic [9:0]        n_id_q;
  logic [2:0]        ibar_q;
  logic [LFSR_N-1:0] c_init_q, c_init_calc;
  logic [OUT_DW-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;

  logic              capture, lfsr_load, lfsr_adv, out_load, last_hs, warm_done;
  logic [1:0]        gold_c;
  logic signed [HW-1:0] sym_re, sym_im;

  assign c_init_calc = calc_c_init(n_id_q, ibar_q);

  gold_seq2 u_gold (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .load_i   (lfsr_load),
    .c_init_i (c_init_calc),
    .en_i     (lfsr_adv),
    .c_o      (gold_c)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (capture)   state_d = LOAD;
      LOAD:                   state_d = WARMUP;
      WARMUP:  if (warm_done) state_d = OUTPUT;
      OUTPUT:  if (last_hs)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / control strobes ----------------
  always_comb begin
    capture   = (state_q == IDLE) && start_i && (N_id_i <= 10'(MAX_CELL_ID));
    lfsr_load = (state_q == LOAD);
    warm_done = (state_q == WARMUP) && (cnt_q == 11'(GOLD_NC / 2 - 1));
    last_hs   = (state_q == OUTPUT) && tvalid_q && m_axis_out_tready && tlast_q;
    // The output register refills when empty (first symbol after warmup)
    // or when its symbol is taken, except after the final symbol.
    out_load  = (state_q == OUTPUT) && (!tvalid_q || m_axis_out_tready) && !last_hs;
    lfsr_adv  = (state_q == WARMUP) || out_load;
    busy_o    = (state_q != IDLE);
  end

  // ---------------- QPSK mapper: bit 0 -> +AMP, bit 1 -> -AMP ----------------
  always_comb begin
    sym_re = gold_c[0] ? NEG : POS;
    sym_im = gold_c[1] ? NEG : POS;
  end

  // ---------------- Counter and output register next state ----------------
  always_comb begin
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    case (state_q)
      LOAD:   cnt_d = '0;
      WARMUP: cnt_d = warm_done ? 11'd0 : cnt_q + 11'd1;
      OUTPUT: begin
        if (out_load) begin
          // cnt_q is the index of the symbol being loaded.
          tdata_d  = {sym_im, sym_re};
          tvalid_d = 1'b1;
          tlast_d  = (cnt_q == 11'(PBCH_DMRS_LEN - 1));
          cnt_d    = cnt_q + 11'd1;
        end else if (last_hs) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q    <= '0;
      n_id_q   <= '0;
      ibar_q   <= '0;
      c_init_q <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      if (capture) begin
        n_id_q <= N_id_i;
        ibar_q <= ibar_SSB_i;
      end
      if (lfsr_load) c_init_q <= c_init_calc;
    end
  end

  assign m_axis_out_tdata  = tdata_q;
  assign m_axis_out_tvalid = tvalid_q;
  assign m_axis_out_tlast  = tlast_q;
  assign debug_c_init_o    = c_init_q;

endmodule

// File: tb/tb_pbch_dmrs_gen.sv
module tb_pbch_dmrs_gen;

  localparam int AMP = 23170;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [9:0]  N_id_i;
  logic [2:0]  ibar_i;
  logic        start_i;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        busy;
  logic [30:0] dbg_cinit;

  pbch_dmrs_gen #(.OUT_DW(32), .AMP(AMP)) dut (
    .clk_i             (clk),
    .reset_ni          (reset_ni),
    .N_id_i            (N_id_i),
    .ibar_SSB_i        (ibar_i),
    .start_i           (start_i),
    .m_axis_out_tdata  (tdata),
    .m_axis_out_tvalid (tvalid),
    .m_axis_out_tready (tready),
    .m_axis_out_tlast  (tlast),
    .busy_o            (busy),
    .debug_c_init_o    (dbg_cinit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- Behavioural reference model ----------------
  logic [31:0] exp_mem [0:143];
  bit          gx1 [0:1919];
  bit          gx2 [0:1919];

  function automatic int model_cinit(input int nid, input int ib);
    return ((ib + 1) * ((nid / 4) + 1)) * 2048 + (ib + 1) * 64 + (nid % 4);
  endfunction

  task automatic build_model(input int nid, input int ib);
    int ci;
    bit c0, c1;
    logic signed [15:0] re, im;
    ci = model_cinit(nid, ib);
    for (int i = 0; i < 31; i++) begin
      gx1[i] = (i == 0);
      gx2[i] = ((ci >> i) & 1) != 0;
    end
    for (int k = 31; k < 1600 + 288; k++) begin
      gx1[k] = gx1[k-28] ^ gx1[k-31];
      gx2[k] = gx2[k-28] ^ gx2[k-29] ^ gx2[k-30] ^ gx2[k-31];
    end
    for (int m = 0; m < 144; m++) begin
      c0 = gx1[1600 + 2*m]     ^ gx2[1600 + 2*m];
      c1 = gx1[1600 + 2*m + 1] ^ gx2[1600 + 2*m + 1];
      re = c0 ? -16'sd23170 : 16'sd23170;
      im = c1 ? -16'sd23170 : 16'sd23170;
      exp_mem[m] = {im, re};
    end
  endtask

  // ---------------- Compare process ----------------
  int          idx = 0;
  int          seq_done = 0;
  bit          hold_v = 0;
  logic [31:0] held_d;
  logic        held_l;

  always @(negedge clk) begin
    if (!reset_ni) begin
      idx    = 0;
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_tvalid", 64'(tvalid), 64'd1);
        chk("hold_tdata", 64'(tdata), 64'(held_d));
        chk("hold_tlast", 64'(tlast), 64'(held_l));
      end
      if (tvalid && tready) begin
        if (idx >= 144) begin
          chk("extra_symbol", 64'(idx), 64'd143);
        end else begin
          chk($sformatf("sym%0d_tdata", idx), 64'(tdata), 64'(exp_mem[idx]));
          chk($sformatf("sym%0d_tlast", idx), 64'(tlast), 64'(idx == 143));
          idx++;
          if (idx == 144) seq_done++;
        end
      end
      hold_v = tvalid && !tready;
      held_d = tdata;
      held_l = tlast;
      if (!busy && !tvalid) idx = 0;
    end
  end

  // ---------------- tready driver ----------------
  int mode = 0;      // 0: always ready, 1: random 50% with a 10-cycle stall at symbol 70
  int low_ctr = 0;
  bit low_done = 0;

  initial begin
    tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (idx == 0) low_done = 0;
      if (mode == 0) begin
        tready = 1'b1;
      end else begin
        if (idx == 70 && !low_done) begin
          low_ctr  = 10;
          low_done = 1;
        end
        if (low_ctr > 0) begin
          tready = 1'b0;
          low_ctr--;
        end else begin
          tready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // ---------------- Request helper ----------------
  task automatic run_req(input int nid, input int ib, input bit inject,
                         output int fv, output int dc);
    int sd0;
    build_model(nid, ib);
    sd0     = seq_done;
    N_id_i  = 10'(nid);
    ibar_i  = 3'(ib);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    fv = 0;
    while (!tvalid && fv < 2000) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      fv++;
      if (inject && fv == 300) begin
        N_id_i  = 10'd77;
        ibar_i  = 3'd1;
        start_i = 1'b1;
      end
    end
    chk("first_tvalid_within_bound", 64'(fv < 2000), 64'd1);
    dc = fv;
    while (busy && dc < fv + 5000) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      dc++;
      if (inject && dc == fv + 20) begin
        N_id_i  = 10'd78;
        start_i = 1'b1;
      end
    end
    start_i = 1'b0;
    chk("busy_drop_within_bound", 64'(busy), 64'd0);
    chk("sequence_complete", 64'(seq_done - sd0), 64'd1);
  endtask

  // ---------------- Main sequence ----------------
  initial begin
    int fv, dc, rn, rb;
    reset_ni = 1'b0;
    start_i  = 1'b0;
    N_id_i   = '0;
    ibar_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cinit", 64'(dbg_cinit), 64'd0);
    reset_ni = 1'b1;
    @(posedge clk);
    #1;

    // Pin the model's c_init against hand-computed values.
    chk("model_cinit_0_0", 64'(model_cinit(0, 0)), 64'h840);
    chk("model_cinit_1007_7", 64'(model_cinit(1007, 7)), 64'h3F0203);

    // N_id 0, ibar 0, always ready
    mode = 0;
    run_req(0, 0, 0, fv, dc);
    chk("t1_first_tvalid_cycle", 64'(fv), 64'd802);
    chk("t1_busy_drop_cycle", 64'(dc), 64'd946);
    chk("t1_cinit", 64'(dbg_cinit), 64'h840);

    // N_id 1007, ibar 7
    run_req(1007, 7, 0, fv, dc);
    chk("t2_first_tvalid_cycle", 64'(fv), 64'd802);
    chk("t2_cinit", 64'(dbg_cinit), 64'h3F0203);

    // Random backpressure with a long stall at symbol 70
    mode = 1;
    run_req(0, 0, 0, fv, dc);
    chk("t3_first_tvalid_cycle", 64'(fv), 64'd802);
    for (int r = 0; r < 2; r++) begin
      rn = $urandom_range(0, 1007);
      rb = $urandom_range(0, 7);
      run_req(rn, rb, 0, fv, dc);
      chk("rand_cinit", 64'(dbg_cinit), 64'(model_cinit(rn, rb)));
    end

    // Starts during WARMUP and OUTPUT are ignored
    mode = 0;
    repeat (2) @(posedge clk);
    #1;
    run_req(300, 3, 1, fv, dc);
    chk("t4_busy_drop_cycle", 64'(dc), 64'd946);
    chk("t4_cinit", 64'(dbg_cinit), 64'(model_cinit(300, 3)));

    // Out-of-range N_id is ignored
    N_id_i  = 10'd1010;
    ibar_i  = 3'd0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bad_nid_busy", 64'(busy), 64'd0);
      chk("bad_nid_tvalid", 64'(tvalid), 64'd0);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset at symbol 40
    build_model(123, 4);
    N_id_i  = 10'd123;
    ibar_i  = 3'd4;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    fv = 0;
    while (idx < 40 && fv < 2000) begin
      @(posedge clk);
      #1;
      fv++;
    end
    chk("reach_symbol40", 64'(idx), 64'd40);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("arst_tdata", 64'(tdata), 64'd0);
    chk("arst_tvalid", 64'(tvalid), 64'd0);
    chk("arst_tlast", 64'(tlast), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cinit", 64'(dbg_cinit), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_ni = 1'b1;
    @(posedge clk);
    #1;
    run_req(123, 4, 0, fv, dc);
    chk("post_reset_first_tvalid", 64'(fv), 64'd802);

    // Back-to-back requests: second start in the cycle after busy falls
    run_req(5, 2, 0, fv, dc);
    chk("b2b_first_busy_drop", 64'(dc), 64'd946);
    run_req(6, 2, 0, fv, dc);
    chk("b2b_second_first_tvalid", 64'(fv), 64'd802);
    chk("b2b_second_cinit", 64'(dbg_cinit), 64'(model_cinit(6, 2)));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
